// File: rtl/tail_light_monitor.sv
// rtl/tail_light_monitor.sv - passive checker/decoder for the six tail-light lamp lines
// Optional saturating error counter enabled by TAIL_LIGHT_MONITOR_ERRCNT_EN.
module tail_light_monitor #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             la,
   input  logic             lb,
   input  logic             lc,
   input  logic             ra,
   input  logic             rb,
   input  logic             rc,
   input  logic             clr,
   output logic [2:0]       mode,
   output logic             mode_valid,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [2:0] {
      M_IDLE        = 3'd0,
      M_LEFT        = 3'd1,
      M_RIGHT       = 3'd2,
      M_HAZARD      = 3'd3,
      M_BRAKE       = 3'd4,
      M_LEFT_BRAKE  = 3'd5,
      M_RIGHT_BRAKE = 3'd6,
      M_UNKNOWN     = 3'd7
   } mode_e;

   function automatic logic legal_code(input logic [2:0] c);
      return (c == 3'b000) || (c == 3'b100) || (c == 3'b110) || (c == 3'b111);
   endfunction

   // An illegal previous code makes every following step illegal.
   function automatic logic legal_trans(input logic [2:0] p, input logic [2:0] c);
      logic ok;
      ok = 1'b0;
      case (p)
         3'b000:  ok = (c == 3'b000) || (c == 3'b100) || (c == 3'b111);
         3'b100:  ok = (c == 3'b110) || (c == 3'b000);
         3'b110:  ok = (c == 3'b111) || (c == 3'b000);
         3'b111:  ok = (c == 3'b000) || (c == 3'b111);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   logic [2:0] l_prev_q, l_prev_d, r_prev_q, r_prev_d;
   logic       turn_l_q, turn_l_d, turn_r_q, turn_r_d;
   logic       rise_q, rise_d, hazard_q, hazard_d;
   mode_e      mode_q, mode_d;
   logic       valid_q, valid_d;
   logic       err_q, err_d;
   logic       sticky_q, sticky_d;

   logic [2:0] l_cur, r_cur;
   logic [5:0] prev6, cur6;
   logic       l_bad, r_bad, toggle;
   logic       l_hold111, r_hold111;

   always_comb begin
      l_cur     = {la, lb, lc};
      r_cur     = {ra, rb, rc};
      prev6     = {l_prev_q, r_prev_q};
      cur6      = {l_cur, r_cur};
      l_bad     = !legal_code(l_cur) || !legal_trans(l_prev_q, l_cur);
      r_bad     = !legal_code(r_cur) || !legal_trans(r_prev_q, r_cur);
      l_hold111 = (l_cur == 3'b111) && (l_prev_q == 3'b111);
      r_hold111 = (r_cur == 3'b111) && (r_prev_q == 3'b111);
      toggle    = ((prev6 == 6'h00) && (cur6 == 6'h3f)) || ((prev6 == 6'h3f) && (cur6 == 6'h00));

      l_prev_d = l_cur;
      r_prev_d = r_cur;

      turn_l_d = turn_l_q;
      if ((l_prev_q == 3'b000) && (l_cur == 3'b100)) turn_l_d = 1'b1;
      if ((l_prev_q == 3'b000) && (l_cur == 3'b000)) turn_l_d = 1'b0;
      if (l_bad) turn_l_d = 1'b0;

      turn_r_d = turn_r_q;
      if ((r_prev_q == 3'b000) && (r_cur == 3'b100)) turn_r_d = 1'b1;
      if ((r_prev_q == 3'b000) && (r_cur == 3'b000)) turn_r_d = 1'b0;
      if (r_bad) turn_r_d = 1'b0;

      // Hazard needs a full rise followed by a full fall; then persists on toggles.
      rise_d   = (prev6 == 6'h00) && (cur6 == 6'h3f);
      hazard_d = (hazard_q && toggle) || (rise_q && (cur6 == 6'h00));

      if (hazard_d)                                mode_d = M_HAZARD;
      else if (turn_l_d && r_hold111)              mode_d = M_LEFT_BRAKE;
      else if (turn_r_d && l_hold111)              mode_d = M_RIGHT_BRAKE;
      else if (turn_l_d && !turn_r_d)              mode_d = M_LEFT;
      else if (turn_r_d && !turn_l_d)              mode_d = M_RIGHT;
      else if (l_hold111 && r_hold111)             mode_d = M_BRAKE;
      else if ((cur6 == 6'h00) && !turn_l_d && !turn_r_d) mode_d = M_IDLE;
      else                                         mode_d = M_UNKNOWN;

      valid_d  = 1'b1;
      err_d    = l_bad || r_bad || (turn_l_d && turn_r_d);
      sticky_d = (clr ? 1'b0 : sticky_q) || err_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l_prev_q <= 3'b000;
         r_prev_q <= 3'b000;
         turn_l_q <= 1'b0;
         turn_r_q <= 1'b0;
         rise_q   <= 1'b0;
         hazard_q <= 1'b0;
         mode_q   <= M_IDLE;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         l_prev_q <= l_prev_d;
         r_prev_q <= r_prev_d;
         turn_l_q <= turn_l_d;
         turn_r_q <= turn_r_d;
         rise_q   <= rise_d;
         hazard_q <= hazard_d;
         mode_q   <= mode_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
      end
   end

`ifdef TAIL_LIGHT_MONITOR_ERRCNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

   // clr zeroes the base first so a same-cycle violation still counts.
   always_comb begin
      cnt_base = clr ? '0 : cnt_q;
      cnt_d    = cnt_base;
      if (err_d && (cnt_base != {CNT_W{1'b1}})) cnt_d = cnt_base + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign err_count = cnt_q;
`else
   assign err_count = '0;
`endif

   assign mode       = mode_q;
   assign mode_valid = valid_q;
   assign err        = err_q;
   assign err_sticky = sticky_q;

endmodule

// File: tb/tb_tail_light_monitor.sv
// tb/tb_tail_light_monitor.sv - directed self-checking bench for tail_light_monitor
module tb_tail_light_monitor;

   logic       clk, reset, la, lb, lc, ra, rb, rc, clr;
   logic [2:0] mode;
   logic       mode_valid, err, err_sticky;
   logic [7:0] err_count;
   int         compared, mismatched;

   tail_light_monitor #(.CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
      .clr(clr), .mode(mode), .mode_valid(mode_valid),
      .err(err), .err_sticky(err_sticky), .err_count(err_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [2:0] l, input logic [2:0] r);
      {la, lb, lc} = l;
      {ra, rb, rc} = r;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] cnt_exp(input int v);
`ifdef TAIL_LIGHT_MONITOR_ERRCNT_EN
      return v;
`else
      return (v > 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   initial begin
      compared = 0;
      mismatched = 0;
      reset = 1'b1;
      clr = 1'b0;
      {la, lb, lc, ra, rb, rc} = 6'b0;
      @(posedge clk);
      #1;
      chk("rst_mode", mode, 0);
      chk("rst_valid", mode_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_sticky", err_sticky, 0);
      chk("rst_count", err_count, 0);
      reset = 1'b0;

      // left turn sequence
      step(3'b000, 3'b000); chk("l0_mode", mode, 0); chk("l0_valid", mode_valid, 1);
      step(3'b100, 3'b000); chk("l1_mode", mode, 1); chk("l1_err", err, 0);
      step(3'b110, 3'b000); chk("l2_mode", mode, 1);
      step(3'b111, 3'b000); chk("l3_mode", mode, 1);
      step(3'b000, 3'b000); chk("l4_mode", mode, 1); chk("l4_err", err, 0);
      step(3'b000, 3'b000); chk("l5_mode", mode, 0); chk("l5_sticky", err_sticky, 0);

      // hazard
      step(3'b111, 3'b111); chk("h0_mode", mode, 7);
      step(3'b000, 3'b000); chk("h1_mode", mode, 3);
      step(3'b111, 3'b111); chk("h2_mode", mode, 3);
      step(3'b000, 3'b000); chk("h3_mode", mode, 3);
      step(3'b111, 3'b111); chk("h4_mode", mode, 3);
      step(3'b000, 3'b000); chk("h5_mode", mode, 3); chk("h5_err", err, 0);
      step(3'b000, 3'b000); chk("h6_mode", mode, 0);

      // right turn with left held 111
      step(3'b111, 3'b100); chk("rb0_mode", mode, 2);
      step(3'b111, 3'b110); chk("rb1_mode", mode, 6);
      step(3'b111, 3'b111); chk("rb2_mode", mode, 6);
      step(3'b000, 3'b000); chk("rb3_mode", mode, 2);
      step(3'b000, 3'b000); chk("rb4_mode", mode, 0); chk("rb4_sticky", err_sticky, 0);

      // brake
      step(3'b111, 3'b111); chk("b0_mode", mode, 7);
      step(3'b111, 3'b111); chk("b1_mode", mode, 4);
      step(3'b000, 3'b000); chk("b2_mode", mode, 0);
      step(3'b000, 3'b000); chk("b3_err", err, 0);

      // illegal code then illegal transition
      step(3'b010, 3'b000); chk("v0_err", err, 1); chk("v0_mode", mode, 7);
      step(3'b000, 3'b000); chk("v1_err", err, 1); chk("v1_mode", mode, 0);
      chk("v1_sticky", err_sticky, 1); chk("v1_count", err_count, cnt_exp(2));
      step(3'b000, 3'b000); chk("v2_err", err, 0); chk("v2_count", err_count, cnt_exp(2));
      clr = 1'b1;
      step(3'b000, 3'b000); chk("clr_sticky", err_sticky, 0); chk("clr_count", err_count, 0);

      // clr together with a violation
      step(3'b010, 3'b000); chk("cv_err", err, 1); chk("cv_sticky", err_sticky, 1);
      chk("cv_count", err_count, cnt_exp(1));
      clr = 1'b0;
      step(3'b000, 3'b000); chk("cv1_count", err_count, cnt_exp(2));
      clr = 1'b1;
      step(3'b000, 3'b000);
      clr = 1'b0;

      // saturation
      for (int i = 0; i < 254; i++) step(3'b010, 3'b000);
      chk("sat254_count", err_count, cnt_exp(254));
      for (int i = 0; i < 46; i++) step(3'b010, 3'b000);
      chk("sat300_count", err_count, cnt_exp(255));
      step(3'b000, 3'b000); chk("sat_exit_err", err, 1); chk("sat_hold", err_count, cnt_exp(255));
      step(3'b000, 3'b000); chk("sat_quiet", err, 0);

      // both turn flags at once
      step(3'b100, 3'b100); chk("bt0_err", err, 1); chk("bt0_mode", mode, 7);
      step(3'b000, 3'b000); chk("bt1_err", err, 1);
      step(3'b000, 3'b000); chk("bt2_err", err, 0); chk("bt2_mode", mode, 0);

      // asynchronous reset mid-turn
      step(3'b100, 3'b000); chk("ar0_mode", mode, 1); chk("ar0_sticky", err_sticky, 1);
      #2 reset = 1'b1;
      #1;
      chk("ar_mode", mode, 0);
      chk("ar_valid", mode_valid, 0);
      chk("ar_err", err, 0);
      chk("ar_sticky", err_sticky, 0);
      chk("ar_count", err_count, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      step(3'b000, 3'b000); chk("ar1_mode", mode, 0); chk("ar1_valid", mode_valid, 1);
      chk("ar1_err", err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
